// File: rtl/exe_hazard_unit.sv
// exe_hazard_unit
//
// Hazard and forwarding controller sitting beside the ID/EXE pipeline
// register. It decides whether the front end stalls for a load-use hazard,
// kills the wrong-path instructions behind a taken branch or jal resolved in
// EXE, and registers the operand forwarding selects so they become valid as
// the ID instruction enters EXE. A one-entry shadow of the MEM-stage
// destination supplies the second forwarding source. Stall and flush cycles
// are counted in saturating debug counters.
//
// Parameters
//   ASIZE : register address width (address 0 is the hard-wired zero register)
//   CSIZE : width of the saturating stall / flush counters
//
// Ports
//   clk, rst       : clock and synchronous active-high reset
//   rs1_addr_ID    : source 1 of the instruction in ID
//   rs2_addr_ID    : source 2 of the instruction in ID
//   uses_rs1_ID    : ID instruction actually reads rs1
//   uses_rs2_ID    : ID instruction actually reads rs2
//   waddr_EXE      : destination register of the instruction in EXE
//   WriteEn_EXE    : instruction in EXE writes the register file
//   memRead_EXE    : instruction in EXE is a load
//   taken_EXE      : branch in EXE resolved taken, or jal in EXE
//   stall_IF_ID    : hold PC and IF/ID (combinational)
//   flush_IF_ID    : replace IF/ID with a NOP (combinational)
//   bubble_ID_EXE  : load a NOP into ID/EXE at the next edge (combinational)
//   fwd_a_EXE      : operand-1 select, 00 regfile / 01 EX/MEM / 10 MEM/WB
//   fwd_b_EXE      : operand-2 select, same encoding
//   stall_cnt      : saturating count of load-use stall cycles
//   flush_cnt      : saturating count of flush cycles

module exe_hazard_unit #(
   parameter int ASIZE = 5,
   parameter int CSIZE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ASIZE-1:0] rs1_addr_ID,
   input  logic [ASIZE-1:0] rs2_addr_ID,
   input  logic             uses_rs1_ID,
   input  logic             uses_rs2_ID,
   input  logic [ASIZE-1:0] waddr_EXE,
   input  logic             WriteEn_EXE,
   input  logic             memRead_EXE,
   input  logic             taken_EXE,
   output logic             stall_IF_ID,
   output logic             flush_IF_ID,
   output logic             bubble_ID_EXE,
   output logic [1:0]       fwd_a_EXE,
   output logic [1:0]       fwd_b_EXE,
   output logic [CSIZE-1:0] stall_cnt,
   output logic [CSIZE-1:0] flush_cnt
);

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_EXM = 2'b01;
   localparam logic [1:0] FWD_MWB = 2'b10;

   // Shadow of the MEM stage destination. EXE is never stalled, so whatever
   // sits in EXE this cycle is in MEM next cycle.
   logic [ASIZE-1:0] mem_waddr;
   logic             mem_wen;

   logic exe_m1, exe_m2;
   logic mem_m1, mem_m2;
   logic lu, fl;
   logic [1:0] fwd_a_nxt, fwd_b_nxt;

   // Write matches; a destination of r0 never produces a hazard.
   assign exe_m1 = WriteEn_EXE && (waddr_EXE != '0) && (waddr_EXE == rs1_addr_ID) && uses_rs1_ID;
   assign exe_m2 = WriteEn_EXE && (waddr_EXE != '0) && (waddr_EXE == rs2_addr_ID) && uses_rs2_ID;
   assign mem_m1 = mem_wen && (mem_waddr != '0) && (mem_waddr == rs1_addr_ID) && uses_rs1_ID;
   assign mem_m2 = mem_wen && (mem_waddr != '0) && (mem_waddr == rs2_addr_ID) && uses_rs2_ID;

   assign lu = memRead_EXE && (exe_m1 || exe_m2);
   assign fl = taken_EXE;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
      stall_IF_ID   = 1'b0;
      flush_IF_ID   = 1'b0;
      bubble_ID_EXE = 1'b0;
      if (fl) begin
         // A taken branch kills the ID instruction anyway, so any load-use
         // hazard it had is moot.
         flush_IF_ID   = 1'b1;
         bubble_ID_EXE = 1'b1;
      end else if (lu) begin
         stall_IF_ID   = 1'b1;
         bubble_ID_EXE = 1'b1;
      end
   end

   // EXE-stage ALU result is the youngest value and wins over MEM. A load in
   // EXE cannot forward; that case is the load-use stall and ends in a bubble.
   always_comb begin
      fwd_a_nxt = FWD_REG;
      if (exe_m1 && !memRead_EXE) fwd_a_nxt = FWD_EXM;
      else if (mem_m1)            fwd_a_nxt = FWD_MWB;
   end

   always_comb begin
      fwd_b_nxt = FWD_REG;
      if (exe_m2 && !memRead_EXE) fwd_b_nxt = FWD_EXM;
      else if (mem_m2)            fwd_b_nxt = FWD_MWB;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_waddr <= '0;
         mem_wen   <= 1'b0;
         fwd_a_EXE <= FWD_REG;
         fwd_b_EXE <= FWD_REG;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         mem_waddr <= waddr_EXE;
         mem_wen   <= WriteEn_EXE;
         // The bubble entering EXE must not carry a forwarding select.
         fwd_a_EXE <= bubble_ID_EXE ? FWD_REG : fwd_a_nxt;
         fwd_b_EXE <= bubble_ID_EXE ? FWD_REG : fwd_b_nxt;
         if (lu && !fl && (stall_cnt != '1)) stall_cnt <= stall_cnt + CSIZE'(1);
         if (fl && (flush_cnt != '1))        flush_cnt <= flush_cnt + CSIZE'(1);
      end
   end

endmodule

// File: tb/tb_exe_hazard_unit.sv
// Directed bench for exe_hazard_unit. Two instances share the stimulus: one
// with default parameters and one with CSIZE=2 to observe counter saturation.

module tb_exe_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_addr_ID, rs2_addr_ID, waddr_EXE;
   logic       uses_rs1_ID, uses_rs2_ID, WriteEn_EXE, memRead_EXE, taken_EXE;

   logic        stall_IF_ID, flush_IF_ID, bubble_ID_EXE;
   logic [1:0]  fwd_a_EXE, fwd_b_EXE;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_stall, s_flush, s_bubble;
   logic [1:0]  s_fwd_a, s_fwd_b;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected counter values, advanced by hand as stall/flush cycles are applied.
   int exp_stall = 0, exp_flush = 0;
   int exp_sat_stall = 0, exp_sat_flush = 0;

   always #5 clk = ~clk;

   exe_hazard_unit #(.ASIZE(5), .CSIZE(16)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
      .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
      .waddr_EXE(waddr_EXE), .WriteEn_EXE(WriteEn_EXE),
      .memRead_EXE(memRead_EXE), .taken_EXE(taken_EXE),
      .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
      .bubble_ID_EXE(bubble_ID_EXE),
      .fwd_a_EXE(fwd_a_EXE), .fwd_b_EXE(fwd_b_EXE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   exe_hazard_unit #(.ASIZE(5), .CSIZE(2)) dut_sat (
      .clk(clk), .rst(rst),
      .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
      .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
      .waddr_EXE(waddr_EXE), .WriteEn_EXE(WriteEn_EXE),
      .memRead_EXE(memRead_EXE), .taken_EXE(taken_EXE),
      .stall_IF_ID(s_stall), .flush_IF_ID(s_flush),
      .bubble_ID_EXE(s_bubble),
      .fwd_a_EXE(s_fwd_a), .fwd_b_EXE(s_fwd_b),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   function automatic int sat3(input int v);
      return (v >= 3) ? 3 : v + 1;
   endfunction

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2,
                        input logic [4:0] wa, input logic we,
                        input logic mr, input logic tk);
      rs1_addr_ID = r1;  rs2_addr_ID = r2;
      uses_rs1_ID = u1;  uses_rs2_ID = u2;
      waddr_EXE   = wa;  WriteEn_EXE = we;
      memRead_EXE = mr;  taken_EXE   = tk;
      #1;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
         tick();
      end
      // Last reset edge sees a live load-use plus a taken branch, and an EXE write to r7.
      drive(7, 7, 1, 1, 7, 1, 1, 1);
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b00 || fwd_b_EXE !== 2'b00) begin
         n_fail++; $display("FAIL reset_fwd: got a=%b b=%b expected 00 00", fwd_a_EXE, fwd_b_EXE);
      end
      n_checks++;
      if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 2'd0 || s_flush_cnt !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt: got stall=%0d flush=%0d sat %0d/%0d expected all 0",
                            stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt);
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({stall_IF_ID, flush_IF_ID, bubble_ID_EXE} !== 3'b000) begin
         n_fail++; $display("FAIL idle_comb: got stall/flush/bubble=%b expected 000",
                            {stall_IF_ID, flush_IF_ID, bubble_ID_EXE});
      end
      // The MEM shadow must have been cleared, so r7 is not forwarded.
      drive(7, 0, 1, 0, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b00) begin
         n_fail++; $display("FAIL reset_shadow: got fwd_a=%b expected 00", fwd_a_EXE);
      end
   endtask

   task automatic test_load_use();
      drive(3, 0, 1, 0, 3, 1, 1, 0);
      n_checks++;
      if ({stall_IF_ID, flush_IF_ID, bubble_ID_EXE} !== 3'b101) begin
         n_fail++; $display("FAIL lu_comb: got stall/flush/bubble=%b expected 101",
                            {stall_IF_ID, flush_IF_ID, bubble_ID_EXE});
      end
      tick();
      exp_stall++; exp_sat_stall = sat3(exp_sat_stall);
      n_checks++;
      if (fwd_a_EXE !== 2'b00) begin
         n_fail++; $display("FAIL lu_bubble_fwd: got fwd_a=%b expected 00", fwd_a_EXE);
      end
      n_checks++;
      if (stall_cnt !== 16'(exp_stall)) begin
         n_fail++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
      end
      // Load now in MEM, EXE holds the bubble; ID instruction re-evaluated.
      drive(3, 0, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if ({stall_IF_ID, bubble_ID_EXE} !== 2'b00) begin
         n_fail++; $display("FAIL lu_one_cycle: got stall/bubble=%b expected 00", {stall_IF_ID, bubble_ID_EXE});
      end
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b10) begin
         n_fail++; $display("FAIL lu_mem_fwd: got fwd_a=%b expected 10", fwd_a_EXE);
      end
      n_checks++;
      if (stall_cnt !== 16'(exp_stall)) begin
         n_fail++; $display("FAIL lu_stall_hold: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_alu_forward();
      drive(0, 5, 0, 1, 5, 1, 0, 0);
      n_checks++;
      if ({stall_IF_ID, flush_IF_ID, bubble_ID_EXE} !== 3'b000) begin
         n_fail++; $display("FAIL alu_no_stall: got stall/flush/bubble=%b expected 000",
                            {stall_IF_ID, flush_IF_ID, bubble_ID_EXE});
      end
      tick();
      n_checks++;
      if (fwd_b_EXE !== 2'b01 || fwd_a_EXE !== 2'b00) begin
         n_fail++; $display("FAIL alu_exe_fwd: got a=%b b=%b expected 00 01", fwd_a_EXE, fwd_b_EXE);
      end
      drive(0, 5, 0, 1, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (fwd_b_EXE !== 2'b10) begin
         n_fail++; $display("FAIL alu_mem_fwd: got fwd_b=%b expected 10", fwd_b_EXE);
      end
      drive(0, 0, 0, 0, 5, 1, 0, 0);
      tick();
      drive(0, 5, 0, 1, 5, 1, 0, 0);
      tick();
      n_checks++;
      if (fwd_b_EXE !== 2'b01) begin
         n_fail++; $display("FAIL alu_exe_over_mem: got fwd_b=%b expected 01", fwd_b_EXE);
      end
      // MEM holds r5, EXE writes r6: rs1 from MEM, rs2 from EXE.
      drive(5, 6, 1, 1, 6, 1, 0, 0);
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b10 || fwd_b_EXE !== 2'b01) begin
         n_fail++; $display("FAIL alu_split: got a=%b b=%b expected 10 01", fwd_a_EXE, fwd_b_EXE);
      end
      // Same addresses but the ID instruction reads neither source.
      drive(6, 6, 0, 0, 6, 1, 0, 0);
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b00 || fwd_b_EXE !== 2'b00) begin
         n_fail++; $display("FAIL alu_unused_src: got a=%b b=%b expected 00 00", fwd_a_EXE, fwd_b_EXE);
      end
   endtask

   task automatic test_flush();
      drive(0, 0, 0, 0, 2, 1, 0, 0);
      tick();
      // MEM holds r2, EXE is a load to r3 read by rs2, and the branch is taken.
      drive(2, 3, 1, 1, 3, 1, 1, 1);
      n_checks++;
      if ({stall_IF_ID, flush_IF_ID, bubble_ID_EXE} !== 3'b011) begin
         n_fail++; $display("FAIL flush_over_lu: got stall/flush/bubble=%b expected 011",
                            {stall_IF_ID, flush_IF_ID, bubble_ID_EXE});
      end
      tick();
      exp_flush++; exp_sat_flush = sat3(exp_sat_flush);
      n_checks++;
      if (fwd_a_EXE !== 2'b00 || fwd_b_EXE !== 2'b00) begin
         n_fail++; $display("FAIL flush_fwd: got a=%b b=%b expected 00 00", fwd_a_EXE, fwd_b_EXE);
      end
      n_checks++;
      if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
         n_fail++; $display("FAIL flush_cnts: got flush=%0d stall=%0d expected %0d %0d",
                            flush_cnt, stall_cnt, exp_flush, exp_stall);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if ({stall_IF_ID, flush_IF_ID, bubble_ID_EXE} !== 3'b011) begin
         n_fail++; $display("FAIL flush_only: got stall/flush/bubble=%b expected 011",
                            {stall_IF_ID, flush_IF_ID, bubble_ID_EXE});
      end
      tick();
      exp_flush++; exp_sat_flush = sat3(exp_sat_flush);
      n_checks++;
      if (flush_cnt !== 16'(exp_flush)) begin
         n_fail++; $display("FAIL flush_cnt2: got %0d expected %0d", flush_cnt, exp_flush);
      end
   endtask

   task automatic test_r0();
      drive(0, 0, 1, 1, 0, 1, 1, 0);
      n_checks++;
      if ({stall_IF_ID, bubble_ID_EXE} !== 2'b00) begin
         n_fail++; $display("FAIL r0_no_stall: got stall/bubble=%b expected 00", {stall_IF_ID, bubble_ID_EXE});
      end
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b00 || fwd_b_EXE !== 2'b00) begin
         n_fail++; $display("FAIL r0_exe_fwd: got a=%b b=%b expected 00 00", fwd_a_EXE, fwd_b_EXE);
      end
      drive(0, 0, 1, 1, 0, 0, 0, 0);
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b00 || fwd_b_EXE !== 2'b00) begin
         n_fail++; $display("FAIL r0_mem_fwd: got a=%b b=%b expected 00 00", fwd_a_EXE, fwd_b_EXE);
      end
   endtask

   task automatic test_back_to_back();
      // Load r1 in EXE; ID is a load reading r1 and writing r4.
      drive(1, 0, 1, 0, 1, 1, 1, 0);
      n_checks++;
      if (stall_IF_ID !== 1'b1) begin
         n_fail++; $display("FAIL chain_stall1: got %b expected 1", stall_IF_ID);
      end
      tick();
      exp_stall++; exp_sat_stall = sat3(exp_sat_stall);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      n_checks++;
      if (stall_IF_ID !== 1'b0) begin
         n_fail++; $display("FAIL chain_release: got %b expected 0", stall_IF_ID);
      end
      tick();
      n_checks++;
      if (fwd_a_EXE !== 2'b10) begin
         n_fail++; $display("FAIL chain_fwd: got fwd_a=%b expected 10", fwd_a_EXE);
      end
      // Second load (r4) now in EXE; next ID instruction reads r4.
      drive(4, 0, 1, 0, 4, 1, 1, 0);
      n_checks++;
      if (stall_IF_ID !== 1'b1) begin
         n_fail++; $display("FAIL chain_stall2: got %b expected 1", stall_IF_ID);
      end
      tick();
      exp_stall++; exp_sat_stall = sat3(exp_sat_stall);
      n_checks++;
      if (stall_cnt !== 16'(exp_stall)) begin
         n_fail++; $display("FAIL chain_cnt: got %0d expected %0d", stall_cnt, exp_stall);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) begin
         drive(8, 0, 1, 0, 8, 1, 1, 0);
         tick();
         exp_stall++; exp_sat_stall = sat3(exp_sat_stall);
         n_checks++;
         if (s_stall_cnt !== 2'(exp_sat_stall) || stall_cnt !== 16'(exp_stall)) begin
            n_fail++; $display("FAIL sat_stall[%0d]: got sat=%0d wide=%0d expected %0d %0d",
                               i, s_stall_cnt, stall_cnt, exp_sat_stall, exp_stall);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         tick();
         exp_flush++; exp_sat_flush = sat3(exp_sat_flush);
         n_checks++;
         if (s_flush_cnt !== 2'(exp_sat_flush) || flush_cnt !== 16'(exp_flush)) begin
            n_fail++; $display("FAIL sat_flush[%0d]: got sat=%0d wide=%0d expected %0d %0d",
                               i, s_flush_cnt, flush_cnt, exp_sat_flush, exp_flush);
         end
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_alu_forward();
      test_flush();
      test_r0();
      test_back_to_back();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_hazard_unit.md
# exe_hazard_unit

Hazard and forwarding controller that consumes the control outputs of the ID/EXE pipeline register and the source fields of the instruction currently in ID. It detects load-use hazards, kills wrong-path instructions after a taken branch or jal resolved in EXE, and produces registered forwarding selects that become valid as the ID instruction enters EXE. It keeps a one-entry shadow of the MEM-stage destination and counts stalls and flushes for debug.

## Interface
- ASIZE, 5, register address width; address 0 is hard-wired zero and never a hazard source
- CSIZE, 16, width of the saturating stall and flush counters
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- rs1_addr_ID  in  ASIZE  source 1 of the instruction in ID
- rs2_addr_ID  in  ASIZE  source 2 of the instruction in ID
- uses_rs1_ID  in  1  ID instruction reads rs1
- uses_rs2_ID  in  1  ID instruction reads rs2
- waddr_EXE  in  ASIZE  destination from ID/EXE register output
- WriteEn_EXE  in  1  write enable from ID/EXE register output
- memRead_EXE  in  1  load flag from ID/EXE register output
- taken_EXE  in  1  branch in EXE resolved taken, or jal in EXE
- stall_IF_ID  out  1  hold PC and IF/ID register (combinational)
- flush_IF_ID  out  1  replace IF/ID contents with NOP (combinational)
- bubble_ID_EXE  out  1  load NOP (all control 0) into ID/EXE next edge (combinational)
- fwd_a_EXE  out  2  operand-1 select for EXE: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result (registered)
- fwd_b_EXE  out  2  operand-2 select, same encoding (registered)
- stall_cnt  out  CSIZE  number of load-use stall cycles, saturating
- flush_cnt  out  CSIZE  number of flush cycles, saturating

## Operation
- Write match for slot S and source r: WriteEn_S && waddr_S != 0 && waddr_S == r && uses_r_ID.
- Load-use hazard (lu): memRead_EXE and write match of EXE slot on rs1 or rs2.
- Flush (fl): taken_EXE.
- Outputs:
  - fl=1: flush_IF_ID=1, bubble_ID_EXE=1, stall_IF_ID=0. Flush overrides lu.
  - lu=1, fl=0: stall_IF_ID=1, bubble_ID_EXE=1, flush_IF_ID=0.
  - Otherwise all three are 0.
- Shadow MEM slot (mem_waddr, mem_wen), updated every edge from waddr_EXE/WriteEn_EXE: EXE always advances to MEM and is never stalled.
- Next forwarding select per source, in priority order:
  - 01 on an EXE-slot write match with memRead_EXE=0.
  - Otherwise 10 on a MEM-slot write match.
  - Otherwise 00.
- fwd_a/b_EXE register the next select each edge, or load 00 when bubble_ID_EXE=1, so the bubble carries no forwarding.
- After a lu stall the load is in MEM, so the re-evaluated ID instruction gets 10.
- Writes from the WB stage are covered by register-file write-through and are not forwarded.
- Counters: stall_cnt +1 per cycle with lu && !fl; flush_cnt +1 per cycle with fl; both hold at all-ones.

## Timing
- Reset: fwd_a_EXE=fwd_b_EXE=00, mem_waddr=0, mem_wen=0, stall_cnt=flush_cnt=0.
- Combinational outputs with all inputs 0 are 0.
- rst overrides any concurrent hazard: state clears on that edge.
- stall/flush/bubble are valid in the same cycle as the inputs, and the pipeline acts on them at the next edge.
- Forwarding selects are one-cycle latency, aligned with the instruction entering EXE.
- A load-use stall lasts exactly one cycle for a single load. A load followed by a dependent load chain stalls once per pair.
- Simultaneous fl and lu: exactly one flush cycle, no stall, flush_cnt increments, stall_cnt unchanged.
- A dependency on r0 never stalls or forwards.

## Test plan
- Reset with all inputs toggling → all outputs 0 after the rst edge; counters 0.
- Load-use: EXE = load to r3 (memRead=1, WriteEn=1), ID reads rs1=r3 → stall=1, bubble=1 for 1 cycle. Next cycle fwd_a_EXE=00 (bubble); the following edge gives fwd_a_EXE=10. stall_cnt=1.
- ALU forward: EXE writes r5 (memRead=0), ID rs2=r5 → no stall; next edge fwd_b_EXE=01. With r5 only in the MEM shadow → 10. With r5 in both EXE and MEM → 01.
- Taken branch with concurrent load-use → flush=1, bubble=1, stall=0; flush_cnt=1, stall_cnt=0; fwd regs 00.
- r0 destination: EXE load writes r0, ID reads r0 → no stall, fwd 00.
- Saturation with CSIZE=2: hold lu for 5 cycles → stall_cnt stops at 3.
